prbs7_checker: RTL and testbench

- Receive-side counterpart of the bit-stream stimulus path around the DFF under test. A generator drives `d`; this block samples the registered `q` stream one bit per enabled clock and checks it against a PRBS7 sequence (x^7+x^6+1).
- Self-synchronises to the incoming stream, declares lock, counts bit errors and drops lock on excessive errors.
- Sits beside the DUT in the bench top, or behind any 1-bit serial link in the design.

---
 rtl/prbs_pkg.sv | 13 +
 rtl/prbs7_gen.sv | 31 +++
 rtl/prbs7_checker.sv | 157 +++++++++++++++
 tb/tb_prbs7_checker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS7 types and next-bit function
package prbs_pkg;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} chk_state_t;

  localparam int PRBS7_LEN = 7;

  // x^7 + x^6 + 1: next bit from the last seven bits, newest in bit 0
  function automatic logic prbs7_next(input logic [6:0] s);
    return s[6] ^ s[5];
  endfunction

endpackage

// File: rtl/prbs7_gen.sv
// rtl/prbs7_gen.sv - free-running PRBS7 source with enable and reset seed
module prbs7_gen
  import prbs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] seed,
  output logic       prbs_bit
);

  logic [6:0] state_q, state_d;

  // A zero seed is a lock-up state and yields a constant 0 stream
  always_comb begin
    prbs_bit = prbs7_next(state_q);
    state_d  = state_q;
    if (en) begin
      state_d = {state_q[5:0], prbs_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/prbs7_checker.sv
// rtl/prbs7_checker.sv - self-synchronising PRBS7 bit checker with lock and error counting
module prbs7_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT   = 16,
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rx_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  chk_state_t       state_q, state_d;
  logic [6:0]       lfsr_q, lfsr_d;
  logic [2:0]       fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [15:0]      win_q, win_d;
  logic [15:0]      win_err_q, win_err_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic             pred;
  logic             mismatch;
  logic [6:0]       lfsr_rx;
  logic [15:0]      win_err_inc;

  always_comb begin
    pred        = prbs7_next(lfsr_q);
    mismatch    = rx_bit ^ pred;
    lfsr_rx     = {lfsr_q[5:0], rx_bit};
    win_err_inc = win_err_q + 16'(mismatch);

    state_d     = state_q;
    lfsr_d      = lfsr_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_d       = win_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;

    if (en) begin
      unique case (state_q)
        HUNT: begin
          lfsr_d = lfsr_rx;
          if (fill_q == 3'(PRBS7_LEN - 1)) begin
            state_d = VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end

        VERIFY: begin
          lfsr_d = lfsr_rx;
          // an all-zero register would predict zeros forever; refuse it
          if (lfsr_rx == 7'h00) begin
            state_d = HUNT;
            fill_d  = '0;
            match_d = '0;
          end else if (mismatch) begin
            match_d = '0;
          end else if (match_q + 8'd1 == 8'(LOCK_CNT)) begin
            state_d   = LOCKED;
            match_d   = '0;
            win_d     = '0;
            win_err_d = '0;
          end else begin
            match_d = match_q + 8'd1;
          end
        end

        LOCKED: begin
          // free-run on the prediction so a flipped bit is counted once
          lfsr_d = {lfsr_q[5:0], pred};
          if (bit_cnt_q != '1) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + CNT_W'(1);
            end
          end
          if (win_err_inc >= 16'(ERR_THRESH)) begin
            state_d   = HUNT;
            fill_d    = '0;
            win_d     = '0;
            win_err_d = '0;
          end else if (win_q + 16'd1 == 16'(WINDOW)) begin
            win_d     = '0;
            win_err_d = '0;
          end else begin
            win_d     = win_q + 16'd1;
            win_err_d = win_err_inc;
          end
        end

        default: begin
          state_d = HUNT;
          fill_d  = '0;
        end
      endcase
    end

    if (clr_cnt) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      lfsr_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_q       <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_q       <= win_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;
  assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// tb/tb_prbs7_checker.sv - table and scoreboard bench for prbs7_checker
module tb_prbs7_checker;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, en, rx_bit, clr_cnt;
  logic          locked, err_pulse;
  logic [CW-1:0] err_count, bit_count;
  logic          gen_rst, gen_en, gen_bit;
  logic [6:0]    seed;

  always #5 clk = ~clk;

  prbs7_checker #(
    .LOCK_CNT(16), .WINDOW(64), .ERR_THRESH(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .rx_bit(rx_bit), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .bit_count(bit_count)
  );

  prbs7_gen gen (
    .clk(clk), .rst(gen_rst), .en(gen_en), .seed(seed), .prbs_bit(gen_bit)
  );

  typedef struct {
    string         tag;
    logic          locked;
    logic          pulse;
    logic [CW-1:0] ec;
    logic [CW-1:0] bc;
  } exp_t;

  typedef struct {
    string      tag;
    int         mode;     // 0 prbs, 1 stuck-at-0, 2 stuck-at-1
    logic       toggle;   // idle cycle before every valid bit
    logic [6:0] seed;
    int         nbits;
    int         lock_at;  // valid-bit index whose response shows lock, 0 = never
  } vec_t;

  exp_t          sb[$];
  vec_t          vt[5];
  int            total = 0;
  int            bad   = 0;
  int            src_mode = 0;
  logic          e_lock;
  logic [CW-1:0] e_ec, e_bc;

  task automatic cmp(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, want);
    end
  endtask

  task automatic step(input logic e, input logic inj, input logic clr,
                      input logic pulse, input string tag);
    exp_t x;
    @(negedge clk);
    en      = e;
    gen_en  = e;
    clr_cnt = clr;
    if (!e) begin
      rx_bit = 1'($urandom_range(0, 1));
    end else begin
      case (src_mode)
        0:       rx_bit = gen_bit ^ inj;
        1:       rx_bit = 1'b0 ^ inj;
        default: rx_bit = 1'b1 ^ inj;
      endcase
    end
    sb.push_back('{tag, e_lock, pulse, e_ec, e_bc});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    cmp({x.tag, ".locked"},    CW'(locked),    CW'(x.locked));
    cmp({x.tag, ".err_pulse"}, CW'(err_pulse), CW'(x.pulse));
    cmp({x.tag, ".err_count"}, err_count,      x.ec);
    cmp({x.tag, ".bit_count"}, bit_count,      x.bc);
  endtask

  task automatic valid_bit(input logic inj, input logic clr, input logic lock_after,
                           input string tag);
    logic pulse;
    pulse = inj && e_lock;
    if (e_lock) e_bc = e_bc + CW'(1);
    if (pulse)  e_ec = e_ec + CW'(1);
    if (clr) begin
      e_ec = '0;
      e_bc = '0;
    end
    e_lock = lock_after;
    step(1'b1, inj, clr, pulse, tag);
  endtask

  task automatic clean(input int n, input int lock_at, input logic toggle, input string tag);
    for (int k = 1; k <= n; k++) begin
      if (toggle) step(1'b0, 1'b0, 1'b0, 1'b0, tag);
      valid_bit(1'b0, 1'b0, e_lock || (lock_at != 0 && k == lock_at), tag);
    end
  endtask

  task automatic do_reset(input logic reload_gen, input logic [6:0] s, input string tag);
    @(negedge clk);
    rst     = 1'b1;
    gen_rst = reload_gen;
    seed    = s;
    en      = 1'b1;
    gen_en  = 1'b0;
    rx_bit  = 1'($urandom_range(0, 1));
    clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    gen_rst = 1'b0;
    e_lock  = 1'b0;
    e_ec    = '0;
    e_bc    = '0;
    cmp({tag, ".locked"},    CW'(locked),    '0);
    cmp({tag, ".err_pulse"}, CW'(err_pulse), '0);
    cmp({tag, ".err_count"}, err_count,      '0);
    cmp({tag, ".bit_count"}, bit_count,      '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; gen_rst = 1'b1; en = 1'b0; gen_en = 1'b0;
    rx_bit = 1'b0; clr_cnt = 1'b0; seed = 7'h7F;
    e_lock = 1'b0; e_ec = '0; e_bc = '0;

    vt[0] = '{"prbs_7f",   0, 1'b0, 7'h7F, 123, 23};
    vt[1] = '{"stuck0",    1, 1'b0, 7'h7F, 200, 0};
    vt[2] = '{"stuck1",    2, 1'b0, 7'h7F, 200, 0};
    vt[3] = '{"en_toggle", 0, 1'b1, 7'h7F, 60,  23};
    vt[4] = '{"prbs_01",   0, 1'b0, 7'h01, 40,  23};

    for (int i = 0; i < 5; i++) begin
      src_mode = vt[i].mode;
      do_reset(1'b1, vt[i].seed, {vt[i].tag, "_rst"});
      clean(vt[i].nbits, vt[i].lock_at, vt[i].toggle, vt[i].tag);
    end

    src_mode = 0;

    // single flipped bit, then clear racing a second flipped bit
    do_reset(1'b1, 7'h7F, "rst_a");
    clean(23, 23, 1'b0, "lock_a");
    valid_bit(1'b1, 1'b0, 1'b1, "single_err");
    clean(20, 0, 1'b0, "after_single");
    valid_bit(1'b1, 1'b1, 1'b1, "clr_with_err");
    clean(3, 0, 1'b0, "after_clr");

    // four errors inside one window drop lock, clean stream relocks
    do_reset(1'b1, 7'h7F, "rst_b");
    clean(23, 23, 1'b0, "lock_b");
    for (int j = 0; j < 3; j++) begin
      valid_bit(1'b1, 1'b0, 1'b1, "burst_err");
      clean(3, 0, 1'b0, "burst_gap");
    end
    valid_bit(1'b1, 1'b0, 1'b0, "fourth_err");
    clean(23, 23, 1'b0, "relock_b");

    // three errors, window rolls over, the fourth lands in a fresh window
    do_reset(1'b1, 7'h7F, "rst_c");
    clean(23, 23, 1'b0, "lock_c");
    for (int j = 0; j < 3; j++) valid_bit(1'b1, 1'b0, 1'b1, "win_err");
    clean(61, 0, 1'b0, "win_gap");
    valid_bit(1'b1, 1'b0, 1'b1, "next_window_err");
    clean(5, 0, 1'b0, "win_tail");

    // reset while locked, stream keeps running
    do_reset(1'b0, 7'h7F, "rst_mid");
    clean(23, 23, 1'b0, "relock_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
